// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter: FSM encoding, arbitration modes
// and the lock counter width.
package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Wide enough for any LOCK_MAX up to 255.
   localparam int CNT_W = 8;

endpackage

// File: rtl/rr_select.sv
// Rotating priority picker: first set bit of (req & mask), scanning upward from ptr
// with wrap-around. Returns the winner as one-hot and as an index.
module rr_select #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         mask,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   localparam int IW = $clog2(N);

   logic [N-1:0]  eff;
   logic [IW-1:0] pos;
   int            j;

   always_comb begin
      eff    = req & mask;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = 0;
      pos    = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         pos = IW'(j);
         if (!found && eff[pos]) begin
            found       = 1'b1;
            onehot[pos] = 1'b1;
            idx         = pos;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-source bus arbiter with a registered output word, fixed or round-robin
// priority, and bounded bus locking by the current owner.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NUM_SRC  = 4,
   parameter int MODE     = 0,
   parameter int LOCK_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SRC-1:0]       req,
   input  logic [NUM_SRC-1:0]       lock,
   input  logic [NUM_SRC*WIDTH-1:0] data_in,
   input  logic                     ack,
   output logic [WIDTH-1:0]         out,
   output logic                     out_valid,
   output logic [NUM_SRC-1:0]       grant,
   output logic                     locked,
   output state_t                   state_dbg
);

   localparam int IW = $clog2(NUM_SRC);
   localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

   // Handshake: out/grant are presented while out_valid=1 and stay frozen until the
   // consumer raises ack; a new word is loaded on any edge where (!out_valid || ack)
   // and some request is eligible, so ack plus a request reloads with no bubble.

   state_t              state, state_n;
   logic [WIDTH-1:0]    out_n;
   logic                out_valid_n;
   logic [NUM_SRC-1:0]  grant_n;
   logic [IW-1:0]       rr_ptr, rr_ptr_n;
   logic [IW-1:0]       owner, owner_n;
   logic [CNT_W-1:0]    lock_cnt, lock_cnt_n;

   logic [WIDTH-1:0]    src_data [NUM_SRC];
   logic [NUM_SRC-1:0]  owner_oh, mask, win_oh;
   logic [IW-1:0]       sel_ptr, win_idx;
   logic                win_found, cont, limit_hit;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign src_data[i] = data_in[i*WIDTH +: WIDTH];
   end

   // A locked owner that still holds req and lock is the only eligible source.
   assign cont      = (state == ST_LOCKED) && req[owner] && lock[owner];
   assign limit_hit = (state == ST_HOLD) && (lock_cnt == LOCK_MAX_C);
   assign mask      = cont ? owner_oh : '1;
   assign sel_ptr   = (MODE == MODE_RR) ? rr_ptr : '0;

   always_comb begin
      owner_oh        = '0;
      owner_oh[owner] = 1'b1;
   end

   rr_select #(.N(NUM_SRC)) u_sel (
      .req    (req),
      .mask   (mask),
      .ptr    (sel_ptr),
      .onehot (win_oh),
      .idx    (win_idx),
      .found  (win_found)
   );

   always_comb begin
      state_n     = state;
      out_n       = out;
      out_valid_n = out_valid;
      grant_n     = grant;
      rr_ptr_n    = rr_ptr;
      owner_n     = owner;
      lock_cnt_n  = lock_cnt;
      if (!out_valid || ack) begin
         if (win_found) begin
            out_n       = src_data[win_idx];
            out_valid_n = 1'b1;
            grant_n     = win_oh;
            owner_n     = win_idx;
            if (cont)
               lock_cnt_n = (lock_cnt == LOCK_MAX_C) ? lock_cnt : lock_cnt + CNT_W'(1);
            else if (lock[win_idx] && !limit_hit)
               lock_cnt_n = CNT_W'(1);
            else
               lock_cnt_n = '0;
            if (!cont && (MODE == MODE_RR))
               rr_ptr_n = (win_idx == IW'(NUM_SRC - 1)) ? '0 : win_idx + IW'(1);
            // The load that follows a saturated lock is an ordinary arbitration.
            state_n = (lock[win_idx] && !limit_hit && (lock_cnt_n < LOCK_MAX_C))
                      ? ST_LOCKED : ST_HOLD;
         end else if (out_valid) begin
            out_valid_n = 1'b0;
            grant_n     = '0;
            lock_cnt_n  = '0;
            state_n     = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         out       <= '0;
         out_valid <= 1'b0;
         grant     <= '0;
         rr_ptr    <= '0;
         owner     <= '0;
         lock_cnt  <= '0;
      end else begin
         state     <= state_n;
         out       <= out_n;
         out_valid <= out_valid_n;
         grant     <= grant_n;
         rr_ptr    <= rr_ptr_n;
         owner     <= owner_n;
         lock_cnt  <= lock_cnt_n;
      end
   end

   assign locked    = (state == ST_LOCKED);
   assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a fixed-priority instance (LOCK_MAX=8) and a
// round-robin instance (LOCK_MAX=3) driven by the same inputs.
module tb_bus_arbiter;
   import bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, lock;
   logic [63:0] data_in;
   logic        ack;

   logic [15:0] f_out, r_out;
   logic        f_valid, r_valid, f_locked, r_locked;
   logic [3:0]  f_grant, r_grant;
   state_t      f_state, r_state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.WIDTH(16), .NUM_SRC(4), .MODE(0), .LOCK_MAX(8)) dut_fix (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .data_in(data_in), .ack(ack),
      .out(f_out), .out_valid(f_valid), .grant(f_grant), .locked(f_locked),
      .state_dbg(f_state)
   );

   bus_arbiter #(.WIDTH(16), .NUM_SRC(4), .MODE(1), .LOCK_MAX(3)) dut_rr (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .data_in(data_in), .ack(ack),
      .out(r_out), .out_valid(r_valid), .grant(r_grant), .locked(r_locked),
      .state_dbg(r_state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [15:0] v);
      data_in[i*16 +: 16] = v;
   endtask

   task automatic default_data();
      set_src(0, 16'hD000);
      set_src(1, 16'hD111);
      set_src(2, 16'hD222);
      set_src(3, 16'hD333);
   endtask

   task automatic do_reset();
      req  = 4'b0000;
      lock = 4'b0000;
      ack  = 1'b0;
      default_data();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b0000; lock = 4'b0000; ack = 1'b0;
      default_data();
      #3;
      checks++;
      if ({f_out, f_valid, f_grant, f_locked} !== 22'd0) begin
         failures++;
         $display("FAIL reset_fix got out=%h v=%b g=%b l=%b exp all zero", f_out, f_valid, f_grant, f_locked);
      end
      checks++;
      if ({r_out, r_valid, r_grant, r_locked} !== 22'd0) begin
         failures++;
         $display("FAIL reset_rr got out=%h v=%b g=%b l=%b exp all zero", r_out, r_valid, r_grant, r_locked);
      end
      checks++;
      if (f_state !== ST_IDLE || r_state !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_state got f=%0d r=%0d exp %0d", f_state, r_state, ST_IDLE);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 4'b0100;
      step();
      checks++;
      if (f_valid !== 1'b1 || f_grant !== 4'b0100 || f_out !== 16'hD222) begin
         failures++;
         $display("FAIL first_load got v=%b g=%b out=%h exp v=1 g=0100 out=d222", f_valid, f_grant, f_out);
      end
   endtask

   task automatic test_fixed();
      do_reset();
      req = 4'b1010;
      ack = 1'b1;
      for (int c = 0; c < 4; c++) begin
         set_src(1, 16'h1100 + 16'(c));
         step();
         checks++;
         if (f_grant !== 4'b0010 || f_out !== 16'h1100 + 16'(c) || f_valid !== 1'b1) begin
            failures++;
            $display("FAIL fixed[%0d] got g=%b out=%h v=%b exp g=0010 out=%h v=1",
                     c, f_grant, f_out, f_valid, 16'h1100 + 16'(c));
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_g [5];
      logic [15:0] exp_d [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_d = '{16'hD000, 16'hD111, 16'hD222, 16'hD333, 16'hD000};
      do_reset();
      req = 4'b1111;
      ack = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (r_grant !== exp_g[c] || r_out !== exp_d[c]) begin
            failures++;
            $display("FAIL rr_seq[%0d] got g=%b out=%h exp g=%b out=%h",
                     c, r_grant, r_out, exp_g[c], exp_d[c]);
         end
         checks++;
         if (f_grant !== 4'b0001) begin
            failures++;
            $display("FAIL fix_all_req[%0d] got g=%b exp 0001", c, f_grant);
         end
      end
   endtask

   task automatic test_stall();
      logic [3:0] reqs [5];
      reqs = '{4'b1111, 4'b0001, 4'b1000, 4'b0011, 4'b0000};
      do_reset();
      set_src(2, 16'hBEEF);
      req = 4'b0100;
      step();
      checks++;
      if (r_grant !== 4'b0100 || r_out !== 16'hBEEF || f_out !== 16'hBEEF) begin
         failures++;
         $display("FAIL stall_load got rg=%b rout=%h fout=%h exp 0100 beef beef", r_grant, r_out, f_out);
      end
      for (int c = 0; c < 5; c++) begin
         req = reqs[c];
         set_src(2, 16'h5A00 + 16'(c));
         step();
         checks++;
         if (r_out !== 16'hBEEF || r_grant !== 4'b0100 || r_valid !== 1'b1 ||
             f_out !== 16'hBEEF || f_grant !== 4'b0100 || f_state !== ST_HOLD) begin
            failures++;
            $display("FAIL stall[%0d] got rout=%h rg=%b rv=%b fout=%h fg=%b fs=%0d exp beef 0100 1 beef 0100 %0d",
                     c, r_out, r_grant, r_valid, f_out, f_grant, f_state, ST_HOLD);
         end
      end
      ack = 1'b1;
      req = 4'b0001;
      set_src(0, 16'h1234);
      step();
      checks++;
      if (r_grant !== 4'b0001 || r_out !== 16'h1234 || r_valid !== 1'b1 || f_grant !== 4'b0001) begin
         failures++;
         $display("FAIL back_to_back got rg=%b rout=%h rv=%b fg=%b exp 0001 1234 1 0001", r_grant, r_out, r_valid, f_grant);
      end
   endtask

   task automatic test_lock_limit();
      logic [3:0]  exp_g [5];
      logic [15:0] exp_d [5];
      logic        exp_l [5];
      exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
      exp_d = '{16'hD111, 16'hD111, 16'hD111, 16'hD333, 16'hD111};
      exp_l = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      req  = 4'b1010;
      lock = 4'b0010;
      ack  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (r_grant !== exp_g[c] || r_out !== exp_d[c] || r_locked !== exp_l[c]) begin
            failures++;
            $display("FAIL lock_limit[%0d] got g=%b out=%h l=%b exp g=%b out=%h l=%b",
                     c, r_grant, r_out, r_locked, exp_g[c], exp_d[c], exp_l[c]);
         end
         checks++;
         if (f_grant !== 4'b0010 || f_locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_fix[%0d] got g=%b l=%b exp g=0010 l=1", c, f_grant, f_locked);
         end
      end
   endtask

   task automatic test_lock_release();
      do_reset();
      req  = 4'b1010;
      lock = 4'b0010;
      step();
      checks++;
      if (r_grant !== 4'b0010 || r_locked !== 1'b1 || r_state !== ST_LOCKED) begin
         failures++;
         $display("FAIL release_load got g=%b l=%b s=%0d exp 0010 1 %0d", r_grant, r_locked, r_state, ST_LOCKED);
      end
      lock = 4'b0000;
      step();
      checks++;
      if (r_grant !== 4'b0010 || r_locked !== 1'b1 || f_locked !== 1'b1) begin
         failures++;
         $display("FAIL release_hold got rg=%b rl=%b fl=%b exp 0010 1 1", r_grant, r_locked, f_locked);
      end
      ack = 1'b1;
      step();
      checks++;
      if (r_grant !== 4'b1000 || r_locked !== 1'b0 || f_grant !== 4'b0010 || f_locked !== 1'b0) begin
         failures++;
         $display("FAIL release_arb got rg=%b rl=%b fg=%b fl=%b exp 1000 0 0010 0", r_grant, r_locked, f_grant, f_locked);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req  = 4'b0010;
      lock = 4'b0010;
      step();
      checks++;
      if (r_locked !== 1'b1 || r_valid !== 1'b1) begin
         failures++;
         $display("FAIL areset_pre got l=%b v=%b exp 1 1", r_locked, r_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({r_out, r_valid, r_grant, r_locked} !== 22'd0 || r_state !== ST_IDLE) begin
         failures++;
         $display("FAIL areset got out=%h v=%b g=%b l=%b s=%0d exp all zero idle", r_out, r_valid, r_grant, r_locked, r_state);
      end
      #1;
      rst = 1'b0;
      step();
      checks++;
      if (r_valid !== 1'b1 || r_grant !== 4'b0010 || r_out !== 16'hD111) begin
         failures++;
         $display("FAIL areset_reload got v=%b g=%b out=%h exp 1 0010 d111", r_valid, r_grant, r_out);
      end
   endtask

   task automatic test_drain();
      do_reset();
      req = 4'b0001;
      step();
      req = 4'b0000;
      ack = 1'b1;
      step();
      checks++;
      if (r_valid !== 1'b0 || r_grant !== 4'b0000 || r_state !== ST_IDLE ||
          f_valid !== 1'b0 || f_grant !== 4'b0000 || f_state !== ST_IDLE) begin
         failures++;
         $display("FAIL drain got rv=%b rg=%b rs=%0d fv=%b fg=%b fs=%0d exp 0 0000 idle",
                  r_valid, r_grant, r_state, f_valid, f_grant, f_state);
      end
      ack = 1'b0;
      step();
      checks++;
      if (r_valid !== 1'b0 || f_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_idle got rv=%b fv=%b exp 0 0", r_valid, f_valid);
      end
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_round_robin();
      test_stall();
      test_lock_limit();
      test_lock_release();
      test_async_reset();
      test_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
